nms_window_generator: RTL and testbench

Streaming 3x3 neighbourhood generator for the Canny pipeline. It sits between the Sobel gradient stage and the non-maxima-suppression stage. It accepts one raster-ordered gradient-magnitude sample plus a 1-bit gradient direction per valid cycle. It presents the registered 3x3 magnitude window `p00..p22`, with the direction bit of the centre pixel, to the NMS stage, and qualifies each window with `window_valid`.

---
 rtl/nms_window_generator.sv | 106 ++++++++++
 tb/tb_nms_window_generator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/nms_window_generator.sv
// rtl/nms_window_generator.sv - streaming 3x3 magnitude window with centre direction for NMS
module nms_window_generator #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         pixel_in,
    input  logic                          dir_in,
    input  logic                          pixel_valid,
    input  logic                          sof,
    output logic [DATA_WIDTH-1:0]         p00,
    output logic [DATA_WIDTH-1:0]         p01,
    output logic [DATA_WIDTH-1:0]         p02,
    output logic [DATA_WIDTH-1:0]         p10,
    output logic [DATA_WIDTH-1:0]         p11,
    output logic [DATA_WIDTH-1:0]         p12,
    output logic [DATA_WIDTH-1:0]         p20,
    output logic [DATA_WIDTH-1:0]         p21,
    output logic [DATA_WIDTH-1:0]         p22,
    output logic                          grad_dir,
    output logic [$clog2(IMG_WIDTH)-1:0]  center_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] center_y,
    output logic                          window_valid
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic                  r_d12;
    logic [DATA_WIDTH-1:0] r_lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_lb2 [IMG_WIDTH];
    logic                  r_dlb [IMG_WIDTH];

    logic [CW-1:0]         w_col;
    logic [RW-1:0]         w_row;
    logic [DATA_WIDTH-1:0] w_lb1_q;
    logic [DATA_WIDTH-1:0] w_lb2_q;
    logic                  w_dlb_q;

    // sof relocates the current sample to (0,0) before it is used anywhere
    assign w_col   = sof ? '0 : r_col;
    assign w_row   = sof ? '0 : r_row;
    assign w_lb1_q = r_lb1[w_col];
    assign w_lb2_q = r_lb2[w_col];
    assign w_dlb_q = r_dlb[w_col];

    // Line buffers cascade: line 1 holds row-1, line 2 receives what line 1 held (row-2)
    always_ff @(posedge clk) begin
        if (pixel_valid) begin
            r_lb1[w_col] <= pixel_in;
            r_lb2[w_col] <= w_lb1_q;
            r_dlb[w_col] <= dir_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_d12        <= 1'b0;
            p00          <= '0;
            p01          <= '0;
            p02          <= '0;
            p10          <= '0;
            p11          <= '0;
            p12          <= '0;
            p20          <= '0;
            p21          <= '0;
            p22          <= '0;
            grad_dir     <= 1'b0;
            center_x     <= '0;
            center_y     <= '0;
            window_valid <= 1'b0;
        end else if (pixel_valid) begin
            if (w_col == LAST_COL) begin
                r_col <= '0;
                r_row <= (w_row == LAST_ROW) ? '0 : w_row + RW'(1);
            end else begin
                r_col <= w_col + CW'(1);
                r_row <= w_row;
            end
            p00          <= p01;
            p01          <= p02;
            p02          <= w_lb2_q;
            p10          <= p11;
            p11          <= p12;
            p12          <= w_lb1_q;
            p20          <= p21;
            p21          <= p22;
            p22          <= pixel_in;
            // Direction only matters at the centre, so just the middle row is tracked
            r_d12        <= w_dlb_q;
            grad_dir     <= r_d12;
            center_x     <= w_col - CW'(1);
            center_y     <= w_row - RW'(1);
            window_valid <= (w_row >= RW'(2)) && (w_col >= CW'(2));
        end else begin
            window_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_nms_window_generator.sv
// tb/tb_nms_window_generator.sv - randomized bench with image-array reference model
module tb_nms_window_generator;
    localparam int W = 8;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pixel_valid = 1'b0;
    logic       sof = 1'b0;
    logic       dir_in = 1'b0;
    logic [7:0] pixel_in = 8'd0;
    logic [7:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic       grad_dir;
    logic [2:0] center_x;
    logic [2:0] center_y;
    logic       window_valid;

    always #5 clk = ~clk;

    nms_window_generator #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .dir_in(dir_in),
        .pixel_valid(pixel_valid), .sof(sof),
        .p00(p00), .p01(p01), .p02(p02), .p10(p10), .p11(p11), .p12(p12),
        .p20(p20), .p21(p21), .p22(p22), .grad_dir(grad_dir),
        .center_x(center_x), .center_y(center_y), .window_valid(window_valid)
    );

    int checks = 0;
    int failures = 0;

    int img [H][W];
    bit dimg [H][W];
    int m_r = 0, m_c = 0;
    int e_p [9];
    bit e_dir = 0;
    int e_cx = 0, e_cy = 0;
    bit e_wv = 0, e_known = 0, m_live = 0;

    int pcnt = 0;
    int cp00 [1024], cp02 [1024], cp11 [1024], cp20 [1024], cp22 [1024], ccx [1024], ccy [1024];
    bit cdir [1024];

    function automatic int pix(input int r, input int c);
        return r * 16 + c;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: store each sample at its frame position, read the window straight from the image
    task automatic model_update();
        int r, c;
        if (!rst) begin
            m_r = 0; m_c = 0;
            for (int i = 0; i < 9; i++) e_p[i] = 0;
            e_dir = 0; e_cx = 0; e_cy = 0; e_wv = 0; e_known = 1; m_live = 1;
            return;
        end
        if (!pixel_valid) begin
            e_wv = 0;
            return;
        end
        r = sof ? 0 : m_r;
        c = sof ? 0 : m_c;
        img[r][c] = int'(pixel_in);
        dimg[r][c] = dir_in;
        if (r >= 2 && c >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e_p[i*3+j] = img[r-2+i][c-2+j];
            e_dir = dimg[r-1][c-1];
            e_cx = c - 1; e_cy = r - 1;
            e_wv = 1; e_known = 1;
        end else begin
            e_wv = 0; e_known = 0;
        end
        c++;
        if (c == W) begin
            c = 0; r++;
            if (r == H) r = 0;
        end
        m_r = r; m_c = c;
    endtask

    task automatic cyc(input bit rv, input bit pv, input bit sf, input int v, input bit d);
        rst = rv; pixel_valid = pv; sof = sf; pixel_in = v[7:0]; dir_in = d;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic feed(input int r, input int c, input bit sf);
        cyc(1, 1, sf, pix(r, c), bit'((r % 2) ^ (c % 2)));
    endtask

    task automatic gap();
        cyc(1, 0, 0, 0, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                chk("window_valid", int'(window_valid), int'(e_wv));
                if (e_known) begin
                    chk("p00", p00, e_p[0]); chk("p01", p01, e_p[1]); chk("p02", p02, e_p[2]);
                    chk("p10", p10, e_p[3]); chk("p11", p11, e_p[4]); chk("p12", p12, e_p[5]);
                    chk("p20", p20, e_p[6]); chk("p21", p21, e_p[7]); chk("p22", p22, e_p[8]);
                    chk("grad_dir", int'(grad_dir), int'(e_dir));
                    chk("center_x", int'(center_x), e_cx);
                    chk("center_y", int'(center_y), e_cy);
                end
                if (window_valid && pcnt < 1024) begin
                    cp00[pcnt] = p00; cp02[pcnt] = p02; cp11[pcnt] = p11;
                    cp20[pcnt] = p20; cp22[pcnt] = p22;
                    ccx[pcnt] = center_x; ccy[pcnt] = center_y; cdir[pcnt] = grad_dir;
                    pcnt++;
                end
            end
        end
    end

    initial begin
        int base, b2, nd, di;

        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_wv", int'(window_valid), 0);
        chk("rst_p22", p22, 0);

        // continuous frame
        base = pcnt;
        for (int k = 0; k < W*H; k++) feed(k / W, k % W, k == 0);
        gap();
        chk("s1_count", pcnt - base, 24);
        chk("s1_first_p00", cp00[base], 8'h00);
        chk("s1_first_p02", cp02[base], 8'h02);
        chk("s1_first_p11", cp11[base], 8'h11);
        chk("s1_first_p20", cp20[base], 8'h20);
        chk("s1_first_p22", cp22[base], 8'h22);
        chk("s1_first_dir", int'(cdir[base]), 0);
        chk("s1_first_cx", ccx[base], 1);
        chk("s1_first_cy", ccy[base], 1);
        chk("s1_last_p22", cp22[base+23], 8'h57);
        chk("s1_last_p11", cp11[base+23], 8'h46);
        chk("s1_last_cx", ccx[base+23], 6);
        chk("s1_last_cy", ccy[base+23], 4);

        // same frame with random gaps
        base = pcnt;
        for (int k = 0; k < W*H; ) begin
            if ($urandom_range(1, 0) != 0) begin
                feed(k / W, k % W, k == 0);
                k++;
            end else begin
                gap();
            end
        end
        gap();
        chk("s2_count", pcnt - base, 24);
        chk("s2_first_p22", cp22[base], 8'h22);
        chk("s2_last_p22", cp22[base+23], 8'h57);

        // two back-to-back frames, sof only on the first
        base = pcnt;
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < W*H; k++) feed(k / W, k % W, f == 0 && k == 0);
        gap();
        chk("s3_count", pcnt - base, 48);
        chk("s3_f2_p22", cp22[base+24], 8'h22);
        chk("s3_f2_p00", cp00[base+24], 8'h00);

        // mid-frame resync at (3,4)
        base = pcnt;
        for (int k = 0; k <= 3*W + 3; k++) feed(k / W, k % W, k == 0);
        gap();
        chk("s4_pre_count", pcnt - base, 8);
        b2 = pcnt;
        cyc(1, 1, 1, 8'h34, 1'b1);
        chk("s4_sof_wv", int'(window_valid), 0);
        for (int k = 1; k <= 2*W + 2; k++) feed(k / W, k % W, 0);
        gap();
        chk("s4_count", pcnt - b2, 1);
        chk("s4_p22", cp22[b2], 8'h22);
        chk("s4_p00", cp00[b2], 8'h34);
        chk("s4_p11", cp11[b2], 8'h11);
        chk("s4_cx", ccx[b2], 1);

        // reset in the middle of a frame at (4,5)
        for (int k = 0; k <= 4*W + 4; k++) feed(k / W, k % W, k == 0);
        cyc(0, 1, 0, 8'h45, 1'b1);
        cyc(0, 1, 0, 8'h46, 1'b0);
        chk("s5_rst_wv", int'(window_valid), 0);
        chk("s5_rst_p11", p11, 0);
        chk("s5_rst_p22", p22, 0);
        chk("s5_rst_dir", int'(grad_dir), 0);
        chk("s5_rst_cx", int'(center_x), 0);
        chk("s5_rst_cy", int'(center_y), 0);
        b2 = pcnt;
        for (int k = 0; k <= 2*W + 2; k++) feed(k / W, k % W, 0);
        gap();
        chk("s5_count", pcnt - b2, 1);
        chk("s5_p11", cp11[b2], 8'h11);
        chk("s5_p22", cp22[b2], 8'h22);

        // direction alignment: only (3,3) carries dir=1
        base = pcnt;
        for (int k = 0; k < W*H; k++) cyc(1, 1, k == 0, pix(k / W, k % W), k == 3*W + 3);
        gap();
        chk("s6_count", pcnt - base, 24);
        nd = 0; di = base;
        for (int i = base; i < pcnt; i++)
            if (cdir[i]) begin nd++; di = i; end
        chk("s6_dir_count", nd, 1);
        chk("s6_dir_cx", ccx[di], 3);
        chk("s6_dir_cy", ccy[di], 3);
        chk("s6_dir_p11", cp11[di], 8'h33);

        // random data, gaps, occasional resync and reset
        for (int n = 0; n < 800; n++) begin
            cyc($urandom_range(199, 0) != 0, $urandom_range(2, 0) != 0,
                $urandom_range(39, 0) == 0, int'($urandom_range(255, 0)),
                bit'($urandom_range(1, 0)));
        end
        gap();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
